// File: rtl/mem_bus_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the memory bus arbiter:
//   - FSM state encoding (state_t)
//   - requester port identifiers (PORT_CPU / PORT_LDR)
//   - default address / data widths
// No ports (package).
// ----------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int MEM_AW = 8;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;  // control unit: fetch / LOAD / STORE
  localparam logic PORT_LDR = 1'b1;  // program loader / debug peek-poke

endpackage

// File: rtl/mem_bus_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_bus_arb_pick
// Combinational winner selection between the two memory requesters.
//
// Build option: MEM_BUS_ARBITER_RR_EN
//   defined   -> round-robin on contention (grant the port that was not
//                granted last); adds the last_gnt input
//   undefined -> fixed priority, port 0 (CPU) always wins on contention
//
// Ports:
//   req0, req1  in   request lines of port 0 / port 1
//   last_gnt    in   last granted port (only with MEM_BUS_ARBITER_RR_EN)
//   any_req     out  at least one request is pending
//   winner      out  port that gets the grant (meaningful when any_req=1)
// ----------------------------------------------------------------------------
module mem_bus_arb_pick
  import mem_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef MEM_BUS_ARBITER_RR_EN
  input  logic last_gnt,
`endif
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = req0 | req1;
    winner  = PORT_CPU;
    if (req0 && req1) begin
`ifdef MEM_BUS_ARBITER_RR_EN
      winner = ~last_gnt;
`else
      winner = PORT_CPU;
`endif
    end else if (req1) begin
      // A lone requester is granted regardless of history.
      winner = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one synchronous-read memory port between the CPU control unit
// (port 0) and the program loader / debug port (port 1). Each access runs
// IDLE -> ISSUE -> CAPTURE -> ACK: three cycles from request sample to ack,
// one access every four cycles.
//
// Build option: MEM_BUS_ARBITER_RR_EN selects round-robin arbitration on
// contention (default: fixed priority, port 0 wins).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pN_req/we/addr/wdata     port N request, held stable until pN_ack
//   pN_ack                   one-cycle completion pulse
//   pN_rdata                 read data; holds last captured value
//   mem_addr/write_en/
//   mem_write_data           registered memory controls
//   mem_read_data            memory read data, valid one cycle after address
//   busy                     FSM not in IDLE
//   gnt_id                   port currently or last served
// ----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write_en,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data,
  output logic          busy,
  output logic          gnt_id
);

  state_t        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          gnt_id_q, gnt_id_d;
  logic          acc_we_q, acc_we_d;   // direction of the access in flight

  logic any_req;
  logic winner;

`ifdef MEM_BUS_ARBITER_RR_EN
  logic last_q, last_d;
`endif

  mem_bus_arb_pick u_pick (
    .req0     (p0_req),
    .req1     (p1_req),
`ifdef MEM_BUS_ARBITER_RR_EN
    .last_gnt (last_q),
`endif
    .any_req  (any_req),
    .winner   (winner)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    p0_ack_d    = p0_ack_q;
    p1_ack_d    = p1_ack_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    gnt_id_d    = gnt_id_q;
    acc_we_d    = acc_we_q;
`ifdef MEM_BUS_ARBITER_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_id_d    = winner;
          acc_we_d    = (winner == PORT_LDR) ? p1_we    : p0_we;
          mem_addr_d  = (winner == PORT_LDR) ? p1_addr  : p0_addr;
          mem_wdata_d = (winner == PORT_LDR) ? p1_wdata : p0_wdata;
          mem_we_d    = (winner == PORT_LDR) ? p1_we    : p0_we;
`ifdef MEM_BUS_ARBITER_RR_EN
          last_d      = winner;
`endif
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Memory samples address / write strobe at the end of this cycle.
        mem_we_d = 1'b0;
        state_d  = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // Synchronous read data is valid now; writes leave rdata untouched.
        if (gnt_id_q == PORT_LDR) begin
          if (!acc_we_q) p1_rdata_d = mem_read_data;
          p1_ack_d = 1'b1;
        end else begin
          if (!acc_we_q) p0_rdata_d = mem_read_data;
          p0_ack_d = 1'b1;
        end
        state_d = ST_ACK;
      end

      ST_ACK: begin
        // Requests are ignored here so a requester dropping req at the end
        // of its ack cycle is never re-granted.
        p0_ack_d = 1'b0;
        p1_ack_d = 1'b0;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      gnt_id_q    <= 1'b0;
      acc_we_q    <= 1'b0;
`ifdef MEM_BUS_ARBITER_RR_EN
      last_q      <= PORT_LDR;  // so port 0 wins the first contention
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      gnt_id_q    <= gnt_id_d;
      acc_we_q    <= acc_we_d;
`ifdef MEM_BUS_ARBITER_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_write_en   = mem_we_q;
  assign mem_write_data = mem_wdata_q;
  assign p0_ack         = p0_ack_q;
  assign p1_ack         = p1_ack_q;
  assign p0_rdata       = p0_rdata_q;
  assign p1_rdata       = p1_rdata_q;
  assign gnt_id         = gnt_id_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed self-checking bench for mem_bus_arbiter with a small
// synchronous-read memory model. Inputs change and outputs are sampled on
// the falling clock edge. Arbitration expectations follow
// MEM_BUS_ARBITER_RR_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_ack, p1_ack;
  logic [7:0] p0_rdata, p1_rdata;
  logic [7:0] mem_addr, mem_write_data, mem_read_data;
  logic       mem_write_en, busy, gnt_id;

  logic       tb_init;
  logic [7:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(8), .DW(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .p0_req         (p0_req),
    .p0_we          (p0_we),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p0_ack         (p0_ack),
    .p0_rdata       (p0_rdata),
    .p1_req         (p1_req),
    .p1_we          (p1_we),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p1_ack         (p1_ack),
    .p1_rdata       (p1_rdata),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy),
    .gnt_id         (gnt_id)
  );

  // Synchronous-read memory: data for mem_addr appears one cycle later.
  always @(posedge clk) begin
    if (tb_init) mem[8'h10] <= 8'hA5;
    else if (mem_write_en) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  // Drives one access starting at the next rising edge and watches it for
  // seven cycles. Observation n is taken after the n-th rising edge.
  task automatic run_access(input logic port, input logic we,
                            input logic [7:0] addr, input logic [7:0] wdata,
                            output int ack_cyc, output int ack_w,
                            output int other_ack, output int we_cnt,
                            output logic [7:0] addr1, output logic [7:0] wdata1,
                            output logic gnt1);
    ack_cyc = 0; ack_w = 0; other_ack = 0; we_cnt = 0;
    addr1 = '0; wdata1 = '0; gnt1 = 1'b0;
    if (port) begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        addr1 = mem_addr; wdata1 = mem_write_data; gnt1 = gnt_id;
      end
      if (mem_write_en) we_cnt++;
      if ((port ? p1_ack : p0_ack) === 1'b1) begin
        if (ack_cyc == 0) ack_cyc = c;
        ack_w++;
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
      end
      if ((port ? p0_ack : p1_ack) === 1'b1) other_ack++;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tb_init = 1'b1;
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_addr, mem_write_en, mem_write_data} !== 17'd0) begin
      bad++;
      $display("FAIL reset_mem: got addr=%h we=%b wd=%h want all 0", mem_addr, mem_write_en, mem_write_data);
    end
    total++;
    if ({p0_ack, p1_ack, p0_rdata, p1_rdata} !== 18'd0) begin
      bad++;
      $display("FAIL reset_ports: got ack=%b%b rd0=%h rd1=%h want all 0", p0_ack, p1_ack, p0_rdata, p1_rdata);
    end
    total++;
    if ({busy, gnt_id} !== 2'b00) begin
      bad++;
      $display("FAIL reset_status: got busy=%b gnt=%b want 0 0", busy, gnt_id);
    end
    rst = 1'b0;
    tb_init = 1'b0;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_single_read();
    int ac, aw, oa, wc; logic [7:0] a1, w1; logic g1;
    run_access(1'b0, 1'b0, 8'h10, 8'h00, ac, aw, oa, wc, a1, w1, g1);
    total++;
    if (a1 !== 8'h10) begin bad++; $display("FAIL rd_addr: got %h want 10", a1); end
    total++;
    if (ac != 3 || aw != 1) begin bad++; $display("FAIL rd_ack_timing: got cyc=%0d width=%0d want 3 1", ac, aw); end
    total++;
    if (p0_rdata !== 8'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", p0_rdata); end
    total++;
    if (oa != 0 || wc != 0) begin bad++; $display("FAIL rd_side: got p1_ack=%0d we_cycles=%0d want 0 0", oa, wc); end
    $display("single read p0 @10: ack_cyc=%0d rdata=%h", ac, p0_rdata);
  endtask

  task automatic test_write_readback();
    int ac, aw, oa, wc; logic [7:0] a1, w1; logic g1;
    run_access(1'b1, 1'b1, 8'h80, 8'h3C, ac, aw, oa, wc, a1, w1, g1);
    total++;
    if (a1 !== 8'h80 || w1 !== 8'h3C) begin bad++; $display("FAIL wr_mem: got addr=%h data=%h want 80 3c", a1, w1); end
    total++;
    if (wc != 1) begin bad++; $display("FAIL wr_strobe: got %0d cycles want 1", wc); end
    total++;
    if (ac != 3 || aw != 1 || oa != 0 || g1 !== 1'b1) begin
      bad++; $display("FAIL wr_ack: got cyc=%0d w=%0d p0ack=%0d gnt=%b want 3 1 0 1", ac, aw, oa, g1);
    end
    total++;
    if (p1_rdata !== 8'h00) begin bad++; $display("FAIL wr_rdata_hold: got %h want 00", p1_rdata); end
    $display("write p1 @80=3c: ack_cyc=%0d strobe_cycles=%0d", ac, wc);
    run_access(1'b0, 1'b0, 8'h80, 8'h00, ac, aw, oa, wc, a1, w1, g1);
    total++;
    if (p0_rdata !== 8'h3C || ac != 3 || g1 !== 1'b0) begin
      bad++; $display("FAIL readback: got data=%h cyc=%0d gnt=%b want 3c 3 0", p0_rdata, ac, g1);
    end
    $display("readback p0 @80: rdata=%h", p0_rdata);
  endtask

  task automatic test_simultaneous();
    int n = 0, both = 0;
    logic seq [0:3];
    logic gseq [0:3];
    int acyc [0:3];
    logic exp_port;
    do_reset();
    p0_we = 0; p0_addr = 8'h10; p1_we = 0; p1_addr = 8'h80;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (p0_ack === 1'b1 && p1_ack === 1'b1) both++;
      if ((p0_ack === 1'b1 || p1_ack === 1'b1) && n < 4) begin
        seq[n] = p1_ack; gseq[n] = gnt_id; acyc[n] = c; n++;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    total++;
    if (n != 3 || both != 0) begin bad++; $display("FAIL sim_count: got acks=%0d both=%0d want 3 0", n, both); end
    for (int i = 0; i < n && i < 3; i++) begin
`ifdef MEM_BUS_ARBITER_RR_EN
      exp_port = i[0];
`else
      exp_port = 1'b0;
`endif
      total++;
      if (seq[i] !== exp_port || gseq[i] !== exp_port || acyc[i] != 3 + 4 * i) begin
        bad++;
        $display("FAIL sim_round%0d: got port=%b gnt=%b cyc=%0d want %b %b %0d",
                 i, seq[i], gseq[i], acyc[i], exp_port, exp_port, 3 + 4 * i);
      end
      $display("simultaneous round %0d: ack port=%b gnt=%b cyc=%0d", i, seq[i], gseq[i], acyc[i]);
    end
  endtask

  task automatic test_reset_mid();
    int ac, aw, oa, wc; logic [7:0] a1, w1; logic g1;
    p1_we = 0; p1_addr = 8'h10; p1_req = 1'b1;
    @(negedge clk);
    @(negedge clk);            // FSM now in CAPTURE
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (p1_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_ack: got ack=%b busy=%b want 0 0", p1_ack, busy); end
    total++;
    if ({mem_addr, mem_write_en, mem_write_data, p0_ack, p0_rdata, p1_rdata, gnt_id} !== 35'd0) begin
      bad++; $display("FAIL mid_rst_outs: got addr=%h rd0=%h rd1=%h gnt=%b want all 0", mem_addr, p0_rdata, p1_rdata, gnt_id);
    end
    rst = 1'b0;
    run_access(1'b1, 1'b0, 8'h10, 8'h00, ac, aw, oa, wc, a1, w1, g1);
    total++;
    if (ac != 3 || p1_rdata !== 8'hA5) begin bad++; $display("FAIL mid_rst_retry: got cyc=%0d data=%h want 3 a5", ac, p1_rdata); end
    $display("reset mid-access then retry p1 @10: ack_cyc=%0d rdata=%h", ac, p1_rdata);
  endtask

  task automatic test_late_req();
    logic [7:0] busy_v = '0;
    int a0 = 0, a1c = 0;
    logic g5 = 1'b0;
    p0_we = 0; p0_addr = 8'h10; p0_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      busy_v[c-1] = busy;
      if (c == 5) g5 = gnt_id;
      if (p0_ack === 1'b1 && a0 == 0) begin a0 = c; p0_req = 1'b0; end
      if (p1_ack === 1'b1 && a1c == 0) begin a1c = c; p1_req = 1'b0; end
      if (c == 1) begin p1_we = 0; p1_addr = 8'h80; p1_req = 1'b1; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    total++;
    if (a0 != 3 || a1c != 7) begin bad++; $display("FAIL late_ack: got p0=%0d p1=%0d want 3 7", a0, a1c); end
    total++;
    if (busy_v !== 8'b0111_0111) begin bad++; $display("FAIL late_busy: got %b want 01110111", busy_v); end
    total++;
    if (g5 !== 1'b1 || p1_rdata !== 8'h3C) begin bad++; $display("FAIL late_p1: got gnt=%b data=%h want 1 3c", g5, p1_rdata); end
    $display("late request: p0 ack cyc=%0d p1 ack cyc=%0d busy=%b", a0, a1c, busy_v);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_simultaneous();
    test_reset_mid();
    test_late_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
